// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame parser.
package uart_frame_pkg;

   typedef enum logic [2:0] {
      S_ADDR = 3'd0,
      S_CMD  = 3'd1,
      S_LEN  = 3'd2,
      S_PAY  = 3'd3,
      S_CHK  = 3'd4
   } state_e;

   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_CHK  = 2'd1;
   localparam logic [1:0] ERR_OVF  = 2'd2;
   localparam logic [1:0] ERR_TMO  = 2'd3;

   // 2*255+3 = 513 needs ten bits
   localparam int PAY_LEN_W = 10;

   function automatic logic [PAY_LEN_W-1:0] pay_len(input logic [7:0] len);
      return {1'b0, len, 1'b0} + 10'd3;
   endfunction

endpackage

// File: rtl/uart_frame_parser_if.sv
// Byte-in / header / payload / status bundle of the frame parser.
interface uart_frame_parser_if;
   logic [7:0] rx_byte;
   logic       rx_strobe;
   logic [7:0] hdr_addr;
   logic [7:0] hdr_cmd;
   logic [7:0] hdr_len;
   logic       hdr_valid;
   logic [7:0] pl_data;
   logic       pl_last;
   logic       pl_valid;
   logic       pl_ready;
   logic       frame_ok;
   logic       frame_err;
   logic [1:0] err_code;

   modport slave (
      input  rx_byte, rx_strobe, pl_ready,
      output hdr_addr, hdr_cmd, hdr_len, hdr_valid,
             pl_data, pl_last, pl_valid, frame_ok, frame_err, err_code
   );

   modport master (
      output rx_byte, rx_strobe, pl_ready,
      input  hdr_addr, hdr_cmd, hdr_len, hdr_valid,
             pl_data, pl_last, pl_valid, frame_ok, frame_err, err_code
   );
endinterface

// File: rtl/frame_byte_fifo.sv
// Synchronous payload FIFO; a pop frees room for a same-cycle push when full.
module frame_byte_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 9
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         push_i,
   input  logic [W-1:0] din_i,
   input  logic         pop_i,
   output logic [W-1:0] dout_o,
   output logic         empty_o,
   output logic         drop_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   cnt_q, cnt_d;
   logic          pop_ok_s, push_ok_s, full_s;

   assign empty_o   = (cnt_q == '0);
   assign full_s    = (cnt_q == FULL_CNT);
   assign pop_ok_s  = pop_i & ~empty_o;
   assign push_ok_s = push_i & (~full_s | pop_ok_s);
   assign drop_o    = push_i & full_s & ~pop_ok_s;
   assign dout_o    = mem_q[rd_q];

   always_comb begin
      case ({push_ok_s, pop_ok_s})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_ok_s) begin
            mem_q[wr_q] <= din_i;
            wr_q        <= wr_q + 1'b1;
         end
         if (pop_ok_s) rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/uart_frame_parser.sv
// Parses ADDR/CMD/LEN/PAYLOAD/CHK frames from a UART byte stream.
// Optional ADDR_FILTER_EN: frames for other addresses are tracked but produce no outputs.
module uart_frame_parser
   import uart_frame_pkg::*;
#(
   parameter int FIFO_DEPTH  = 16,
   parameter int TIMEOUT_CYC = 50000
`ifdef ADDR_FILTER_EN
   , parameter logic [7:0] NODE_ADDR = 8'h12
`endif
) (
   input  logic               clock,
   input  logic               reset,
   uart_frame_parser_if.slave fp
);
   localparam int TMO_W = $clog2(TIMEOUT_CYC);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
   localparam logic [PAY_LEN_W-1:0] REM_ONE = PAY_LEN_W'(1);

   state_e                state_q, state_d;
   logic                  strobe_q, accept_s, tmo_s, addr_hit_s, push_s, drop_s, empty_s;
   logic [7:0]            chk_q, chk_d, hdr_addr_q, hdr_addr_d, hdr_cmd_q, hdr_cmd_d;
   logic [7:0]            hdr_len_q, hdr_len_d;
   logic [PAY_LEN_W-1:0]  rem_q, rem_d;
   logic [TMO_W-1:0]      idle_q, idle_d;
   logic                  ovf_q, ovf_d, match_q, match_d;
   logic                  hdr_valid_q, hdr_valid_d, frame_ok_q, frame_ok_d, frame_err_q, frame_err_d;
   logic [1:0]            err_code_q, err_code_d;
   logic [8:0]            head_s;

   assign accept_s = fp.rx_strobe & ~strobe_q;
   assign tmo_s    = (state_q != S_ADDR) & ~accept_s & (idle_q == TMO_LAST);
   assign push_s   = accept_s & (state_q == S_PAY) & match_q;

`ifdef ADDR_FILTER_EN
   assign addr_hit_s = (fp.rx_byte == NODE_ADDR);
`else
   assign addr_hit_s = 1'b1;
`endif

   frame_byte_fifo #(.DEPTH(FIFO_DEPTH), .W(9)) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push_i  (push_s),
      .din_i   ({rem_q == REM_ONE, fp.rx_byte}),
      .pop_i   (fp.pl_ready),
      .dout_o  (head_s),
      .empty_o (empty_s),
      .drop_o  (drop_s)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= S_ADDR;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (tmo_s) begin
         state_d = S_ADDR;
      end else if (accept_s) begin
         case (state_q)
            S_ADDR:  state_d = S_CMD;
            S_CMD:   state_d = S_LEN;
            S_LEN:   state_d = S_PAY;
            S_PAY:   state_d = (rem_q == REM_ONE) ? S_CHK : S_PAY;
            S_CHK:   state_d = S_ADDR;
            default: state_d = S_ADDR;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Datapath and registered-output next values, driven by the accepted byte.
   always_comb begin
      chk_d       = chk_q;
      rem_d       = rem_q;
      ovf_d       = ovf_q;
      match_d     = match_q;
      hdr_addr_d  = hdr_addr_q;
      hdr_cmd_d   = hdr_cmd_q;
      hdr_len_d   = hdr_len_q;
      hdr_valid_d = 1'b0;
      frame_ok_d  = 1'b0;
      frame_err_d = 1'b0;
      err_code_d  = err_code_q;
      idle_d      = (state_q == S_ADDR || accept_s || tmo_s) ? '0 : idle_q + 1'b1;
      if (tmo_s) begin
         frame_err_d = match_q;
         err_code_d  = match_q ? ERR_TMO : err_code_q;
      end else if (accept_s) begin
         case (state_q)
            S_ADDR: begin
               chk_d      = fp.rx_byte;
               ovf_d      = 1'b0;
               match_d    = addr_hit_s;
               hdr_addr_d = addr_hit_s ? fp.rx_byte : hdr_addr_q;
            end
            S_CMD: begin
               chk_d     = chk_q ^ fp.rx_byte;
               hdr_cmd_d = match_q ? fp.rx_byte : hdr_cmd_q;
            end
            S_LEN: begin
               chk_d       = chk_q ^ fp.rx_byte;
               rem_d       = pay_len(fp.rx_byte);
               hdr_len_d   = match_q ? fp.rx_byte : hdr_len_q;
               hdr_valid_d = match_q;
            end
            S_PAY: begin
               chk_d = chk_q ^ fp.rx_byte;
               rem_d = rem_q - 1'b1;
               ovf_d = ovf_q | drop_s;
            end
            S_CHK: begin
               if (!match_q) begin
                  err_code_d = err_code_q;
               end else if (ovf_q) begin
                  frame_err_d = 1'b1;
                  err_code_d  = ERR_OVF;
               end else if (fp.rx_byte == chk_q) begin
                  frame_ok_d = 1'b1;
                  err_code_d = ERR_NONE;
               end else begin
                  frame_err_d = 1'b1;
                  err_code_d  = ERR_CHK;
               end
            end
            default: chk_d = chk_q;
         endcase
      end else begin
         chk_d = chk_q;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         strobe_q    <= 1'b0;
         chk_q       <= '0;
         rem_q       <= '0;
         idle_q      <= '0;
         ovf_q       <= 1'b0;
         match_q     <= 1'b0;
         hdr_addr_q  <= '0;
         hdr_cmd_q   <= '0;
         hdr_len_q   <= '0;
         hdr_valid_q <= 1'b0;
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;
         err_code_q  <= ERR_NONE;
      end else begin
         strobe_q    <= fp.rx_strobe;
         chk_q       <= chk_d;
         rem_q       <= rem_d;
         idle_q      <= idle_d;
         ovf_q       <= ovf_d;
         match_q     <= match_d;
         hdr_addr_q  <= hdr_addr_d;
         hdr_cmd_q   <= hdr_cmd_d;
         hdr_len_q   <= hdr_len_d;
         hdr_valid_q <= hdr_valid_d;
         frame_ok_q  <= frame_ok_d;
         frame_err_q <= frame_err_d;
         err_code_q  <= err_code_d;
      end
   end

   assign fp.hdr_addr  = hdr_addr_q;
   assign fp.hdr_cmd   = hdr_cmd_q;
   assign fp.hdr_len   = hdr_len_q;
   assign fp.hdr_valid = hdr_valid_q;
   assign fp.pl_data   = head_s[7:0];
   assign fp.pl_last   = head_s[8];
   assign fp.pl_valid  = ~empty_s;
   assign fp.frame_ok  = frame_ok_q;
   assign fp.frame_err = frame_err_q;
   assign fp.err_code  = err_code_q;
endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser with a payload scoreboard queue.
module tb_uart_frame_parser;
   localparam int DEPTH = 16;
   localparam int TMO   = 400;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   uart_frame_parser_if bus ();

   uart_frame_parser #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
      .clock (clock),
      .reset (reset),
      .fp    (bus)
   );

   int         checks = 0;
   int         errors = 0;
   logic [8:0] exp_q [$];
   int         hdr_seen, ok_seen, err_seen;
   logic [7:0] hdr_a, hdr_c, hdr_l;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Output monitor: scoreboard pops and pulse counting, sampled on the falling edge.
   always @(negedge clock) begin
      if (bus.pl_valid === 1'b1 && bus.pl_ready === 1'b1) begin
         check("pl_pending", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) check("pl_word", {23'd0, bus.pl_last, bus.pl_data}, {23'd0, exp_q.pop_front()});
      end
      if (bus.hdr_valid === 1'b1) begin
         hdr_seen++;
         hdr_a = bus.hdr_addr;
         hdr_c = bus.hdr_cmd;
         hdr_l = bus.hdr_len;
      end
      if (bus.frame_ok === 1'b1)  ok_seen++;
      if (bus.frame_err === 1'b1) err_seen++;
   end

   task automatic send_byte(input logic [7:0] b, input int hold);
      @(posedge clock); #1;
      bus.rx_byte   = b;
      bus.rx_strobe = 1'b1;
      repeat (hold) @(posedge clock);
      #1 bus.rx_strobe = 1'b0;
      @(posedge clock);
   endtask

   // npay < 0 sends the whole frame; otherwise stops after npay payload bytes.
   task automatic send_frame(input logic [7:0] addr, input logic [7:0] cmd, input logic [7:0] len,
                             input logic bad, input int hold, input int keep, input int npay);
      int         n;
      logic [7:0] chk, b;
      n   = 2 * int'(len) + 3;
      chk = addr ^ cmd ^ len;
      send_byte(addr, hold);
      send_byte(cmd, hold);
      send_byte(len, hold);
      for (int i = 0; i < n; i++) begin
         if (npay >= 0 && i >= npay) return;
         b   = 8'hA0 + 8'(i);
         chk = chk ^ b;
         if (i < keep) exp_q.push_back({(i == n - 1), b});
         send_byte(b, hold);
      end
      send_byte(bad ? (chk ^ 8'h07) : chk, hold);
   endtask

   task automatic clear_seen();
      hdr_seen = 0;
      ok_seen  = 0;
      err_seen = 0;
   endtask

   task automatic good_frame(input string tag, input int hold);
      clear_seen();
      send_frame(8'h12, 8'h34, 8'h01, 1'b0, hold, 1000, -1);
      repeat (10) @(posedge clock);
      #1;
      check({tag, "_hdr_cnt"}, hdr_seen, 1);
      check({tag, "_hdr_addr"}, hdr_a, 8'h12);
      check({tag, "_hdr_cmd"}, hdr_c, 8'h34);
      check({tag, "_hdr_len"}, hdr_l, 8'h01);
      check({tag, "_ok_cnt"}, ok_seen, 1);
      check({tag, "_err_cnt"}, err_seen, 0);
      check({tag, "_err_code"}, bus.err_code, 2'd0);
      check({tag, "_drained"}, exp_q.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int waited;
      reset         = 1'b1;
      bus.rx_byte   = 8'h00;
      bus.rx_strobe = 1'b0;
      bus.pl_ready  = 1'b0;
      clear_seen();
      repeat (3) @(posedge clock);
      #1;
      check("rst_hdr_addr", bus.hdr_addr, 8'h00);
      check("rst_hdr_valid", bus.hdr_valid, 1'b0);
      check("rst_pl_valid", bus.pl_valid, 1'b0);
      check("rst_pl_data", bus.pl_data, 8'h00);
      check("rst_frame_ok", bus.frame_ok, 1'b0);
      check("rst_frame_err", bus.frame_err, 1'b0);
      check("rst_err_code", bus.err_code, 2'd0);
      reset = 1'b0;

      // Basic frame, then bad checksum with payload still delivered.
      bus.pl_ready = 1'b1;
      good_frame("t1", 1);
      clear_seen();
      send_frame(8'h12, 8'h34, 8'h01, 1'b1, 1, 1000, -1);
      repeat (10) @(posedge clock);
      #1;
      check("t2_err_cnt", err_seen, 1);
      check("t2_ok_cnt", ok_seen, 0);
      check("t2_err_code", bus.err_code, 2'd1);
      check("t2_drained", exp_q.size(), 0);

      // Overflow: consumer stalled, only DEPTH bytes survive.
      bus.pl_ready = 1'b0;
      clear_seen();
      send_frame(8'h12, 8'h34, 8'h20, 1'b0, 1, DEPTH, -1);
      repeat (5) @(posedge clock);
      #1;
      check("t3_err_cnt", err_seen, 1);
      check("t3_ok_cnt", ok_seen, 0);
      check("t3_err_code", bus.err_code, 2'd2);
      check("t3_hdr_len", hdr_l, 8'h20);
      check("t3_pl_valid", bus.pl_valid, 1'b1);
      bus.pl_ready = 1'b1;
      repeat (DEPTH + 5) @(posedge clock);
      #1;
      check("t3_drained", exp_q.size(), 0);
      check("t3_empty", bus.pl_valid, 1'b0);

      // Timeout mid-payload, then recovery.
      clear_seen();
      send_frame(8'h12, 8'h34, 8'h01, 1'b0, 1, 2, 2);
      repeat (TMO - 20) @(posedge clock);
      #1;
      check("t4_no_early_tmo", err_seen, 0);
      waited = 0;
      while (err_seen == 0 && waited < 60) begin
         @(posedge clock);
         waited++;
      end
      repeat (5) @(posedge clock);
      #1;
      check("t4_err_cnt", err_seen, 1);
      check("t4_err_code", bus.err_code, 2'd3);
      check("t4_drained", exp_q.size(), 0);
      good_frame("t4b", 1);

      // Long strobe: one accept per rising edge.
      good_frame("t5", 5);

      // Reset mid-payload flushes everything silently.
      bus.pl_ready = 1'b0;
      clear_seen();
      send_frame(8'h12, 8'h34, 8'h01, 1'b0, 1, 3, 3);
      #1;
      check("t6_pre_valid", bus.pl_valid, 1'b1);
      #2 reset = 1'b1;
      #20;
      check("t6_pl_valid", bus.pl_valid, 1'b0);
      check("t6_hdr_addr", bus.hdr_addr, 8'h00);
      check("t6_hdr_len", bus.hdr_len, 8'h00);
      check("t6_err_code", bus.err_code, 2'd0);
      @(posedge clock);
      #1 reset = 1'b0;
      exp_q.delete();
      check("t6_no_err", err_seen, 0);
      bus.pl_ready = 1'b1;
      repeat (3) @(posedge clock);
      good_frame("t6b", 1);

`ifdef ADDR_FILTER_EN
      // Foreign address: tracked but silent.
      clear_seen();
      send_frame(8'h55, 8'h34, 8'h01, 1'b0, 1, 0, -1);
      repeat (10) @(posedge clock);
      #1;
      check("t7_hdr_cnt", hdr_seen, 0);
      check("t7_ok_cnt", ok_seen, 0);
      check("t7_err_cnt", err_seen, 0);
      check("t7_pl_valid", bus.pl_valid, 1'b0);
      good_frame("t7b", 1);
`else
      // Without filtering any address is processed.
      clear_seen();
      send_frame(8'h55, 8'h34, 8'h01, 1'b0, 1, 1000, -1);
      repeat (10) @(posedge clock);
      #1;
      check("t7_hdr_cnt", hdr_seen, 1);
      check("t7_hdr_addr", hdr_a, 8'h55);
      check("t7_ok_cnt", ok_seen, 1);
      check("t7_drained", exp_q.size(), 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
